// File: rtl/fp_mult_collect_pkg.sv
// Shared FP32 field positions and class-vector bit indices for the fp datapath blocks.
package fp_mult_collect_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam int CLS_W    = 5;
  localparam int CLS_NAN  = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_ZERO = 2;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NEG  = 0;
endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier producing {nan, inf, zero, sub, neg}.
module fp32_classify
  import fp_mult_collect_pkg::*;
(
  input  logic [31:0]      val,
  output logic [CLS_W-1:0] cls
);
  logic [EXP_MSB-EXP_LSB:0] exp_f;
  logic [MANT_W-1:0]        mant_f;

  assign exp_f  = val[EXP_MSB:EXP_LSB];
  assign mant_f = val[MANT_W-1:0];

  always_comb begin
    cls           = '0;
    cls[CLS_NAN]  = (exp_f == EXP_MAX) && (mant_f != '0);
    cls[CLS_INF]  = (exp_f == EXP_MAX) && (mant_f == '0);
    cls[CLS_ZERO] = (exp_f == '0) && (mant_f == '0);
    cls[CLS_SUB]  = (exp_f == '0) && (mant_f != '0);
    // Raw sign bit, kept even for NaN and zero.
    cls[CLS_NEG]  = val[SIGN_BIT];
  end
endmodule

// File: rtl/fp_mult_collect.sv
// Collector for fp_mult products: classifies, buffers in a small FIFO with valid/ready,
// and tracks sticky class flags plus a saturating count of dropped products.
module fp_mult_collect
  import fp_mult_collect_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_res,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_res,
  output logic [CLS_W-1:0]         out_cls,
  input  logic                     flags_clr,
  output logic [CLS_W-1:0]         sticky_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [CLS_W-1:0] cls_in;
  logic             push, pop, drop;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CLS_W-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [31:0]      res_mem [DEPTH];
  logic [CLS_W-1:0] cls_mem [DEPTH];

  fp32_classify u_classify (
    .val (in_res),
    .cls (cls_in)
  );

  assign out_valid    = (level_q != '0);
  assign full         = (level_q == LVL_W'(DEPTH));
  assign level        = level_q;
  assign sticky_flags = sticky_q;
  assign drop_cnt     = drop_q;
  // Storage is not reset, so the head is masked to zero while empty.
  assign out_res      = out_valid ? res_mem[rd_ptr_q] : '0;
  assign out_cls      = out_valid ? cls_mem[rd_ptr_q] : '0;

  always_comb begin
    pop  = out_valid & out_ready;
    push = in_valid & (~full | pop);
    drop = in_valid & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    sticky_d = (flags_clr ? '0 : sticky_q) | (push ? cls_in : '0);
    drop_d   = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q] <= in_res;
      cls_mem[wr_ptr_q] <= cls_in;
    end
  end
endmodule
